// File: rtl/md_sched_if.sv
// md_sched_if: connection bundle between the E/D pipeline stages and the
// multiply/divide sequencer.
//   master : pipeline side; drives the issue, operands, cancel and D-stage class
//   slave  : md_sched side; returns busy, stall and the HI/LO registers
//   start   E stage holds a valid md-class instruction
//   op      0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   a, b    forwarded rs / rt operands
//   cancel  exception or interrupt taken this cycle
//   md_in_d D-stage instruction is md-class
//   busy    unit occupied
//   stall   freeze PC, F/D and D/E registers
//   hi, lo  architectural HI/LO registers
interface md_sched_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        md_in_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, cancel, md_in_d,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel, md_in_d,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/md_sched.sv
// md_sched: sequencer for the E-stage multiply/divide resource and owner of
// the HI/LO registers.
//   clk    system clock, rising edge
//   reset  synchronous, active low
//   bus    md_sched_if.slave: start/op/a/b/cancel/md_in_d in,
//          busy/stall/hi/lo out
// Results are computed at the issue edge and held as pending values; the
// busy period only models the latency of the real unit, and the pending
// values are committed to HI/LO at the last busy edge.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    md_sched_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        busy_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] pend_hi_reg;
    logic [31:0] pend_lo_reg;
    logic        pend_valid_reg;

    // ------------------------------------------------------------------
    // Result datapath, evaluated from the current operands
    // ------------------------------------------------------------------
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] den;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        issue_ok;
    logic        is_long_op;

    // Low 64 bits of a sign-extended product equal the signed product.
    assign prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

    // Signed divide is done on magnitudes, then signs are restored:
    // quotient truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally: the magnitude 0x80000000
    // negates back to itself and the remainder is zero.
    assign div_signed = (bus.op == 3'd2);
    assign a_neg      = div_signed & bus.a[31];
    assign b_neg      = div_signed & bus.b[31];
    assign mag_a      = a_neg ? (32'd0 - bus.a) : bus.a;
    assign mag_b      = b_neg ? (32'd0 - bus.b) : bus.b;
    // Keep the divider defined for b==0; the result is discarded anyway.
    assign den        = (bus.b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag      = mag_a / den;
    assign r_mag      = mag_a % den;
    assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

    assign issue_ok   = bus.start && !bus.cancel;
    assign is_long_op = (bus.op <= 3'd3);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            busy_reg       <= 1'b0;
            hi_reg         <= 32'd0;
            lo_reg         <= 32'd0;
            pend_hi_reg    <= 32'd0;
            pend_lo_reg    <= 32'd0;
            pend_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue_ok) begin
                        case (bus.op)
                            3'd0: begin
                                state_reg      <= RUN;
                                busy_reg       <= 1'b1;
                                cnt_reg        <= MULT_CNT;
                                pend_hi_reg    <= prod_s[63:32];
                                pend_lo_reg    <= prod_s[31:0];
                                pend_valid_reg <= 1'b1;
                            end
                            3'd1: begin
                                state_reg      <= RUN;
                                busy_reg       <= 1'b1;
                                cnt_reg        <= MULT_CNT;
                                pend_hi_reg    <= prod_u[63:32];
                                pend_lo_reg    <= prod_u[31:0];
                                pend_valid_reg <= 1'b1;
                            end
                            3'd2, 3'd3: begin
                                state_reg      <= RUN;
                                busy_reg       <= 1'b1;
                                cnt_reg        <= DIV_CNT;
                                pend_hi_reg    <= rem;
                                pend_lo_reg    <= quot;
                                // Divide by zero still runs the full
                                // latency but leaves HI/LO untouched.
                                pend_valid_reg <= (bus.b != 32'd0);
                            end
                            3'd4: hi_reg <= bus.a;
                            3'd5: lo_reg <= bus.a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // start and cancel are deliberately ignored here: an
                    // issued operation always runs to completion.
                    if (cnt_reg == 4'd1) begin
                        if (pend_valid_reg) begin
                            hi_reg <= pend_hi_reg;
                            lo_reg <= pend_lo_reg;
                        end
                        pend_valid_reg <= 1'b0;
                        cnt_reg        <= 4'd0;
                        busy_reg       <= 1'b0;
                        state_reg      <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    cnt_reg   <= 4'd0;
                end
            endcase
        end
    end

    // An md-class instruction in D must wait while the unit is busy, and
    // also during the issue cycle of a long op (its results are not yet
    // committed). mfhi/mflo therefore read HI/LO in the commit-visible cycle.
    assign bus.stall = bus.md_in_d && (busy_reg || (issue_ok && is_long_op));
    assign bus.busy  = busy_reg;
    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;

endmodule
